pixel_recon: RTL and testbench

//  Decoder-side counterpart of the pixel neighbourhood/gradient receiver. Consumes a raster

---
 rtl/pixel_recon.sv | 138 +++++++++++++
 tb/tb_pixel_recon.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_recon.sv
// rtl/pixel_recon.sv - MED-predicted pixel reconstruction from a raster residual stream
// Optional gradient outputs enabled by defining PIXEL_RECON_GRAD_EN.
module pixel_recon #(
    parameter int IMAGE_W = 11,
    parameter int IMAGE_H = 9,
    parameter int PIX_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [PIX_W:0]   res_data,
    input  logic             res_sof,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_sol,
    output logic             pix_eof,
    output logic             frame_err,
    output logic [PIX_W-1:0] grad_d1,
    output logic [PIX_W-1:0] grad_d2,
    output logic [PIX_W-1:0] grad_d3
);
    localparam int CW = $clog2(IMAGE_W);
    localparam int RW = (IMAGE_H > 1) ? $clog2(IMAGE_H) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_H - 1);

    logic [CW-1:0]    col, eff_col;
    logic [RW-1:0]    row, eff_row;
    logic [PIX_W-1:0] linebuf [IMAGE_W];
    logic [PIX_W-1:0] ra_q, prev_rb_q;
    logic [PIX_W-1:0] ra, rb, rc, px, rx, max_ab, min_ab;
    logic [PIX_W+1:0] sum;
    logic             accept, sof_err;

    assign res_ready = !pix_valid || pix_ready;
    assign accept    = res_valid && res_ready;
    assign sof_err   = res_sof && (col != '0 || row != '0);
    // A start-of-frame marker forces the pixel to (0,0) regardless of the counters.
    assign eff_col   = res_sof ? '0 : col;
    assign eff_row   = res_sof ? '0 : row;

    always_comb begin
        rb     = (eff_row == '0) ? '0 : linebuf[eff_col];
        rc     = (eff_col == '0) ? rb : prev_rb_q;
        ra     = (eff_col == '0) ? rb : ra_q;
        max_ab = (ra > rb) ? ra : rb;
        min_ab = (ra > rb) ? rb : ra;
        if (rc >= max_ab)
            px = min_ab;
        else if (rc <= min_ab)
            px = max_ab;
        else
            px = PIX_W'({1'b0, ra} + {1'b0, rb} - {1'b0, rc});
        sum = {2'b00, px} + {res_data[PIX_W], res_data};
        if (sum[PIX_W+1])
            rx = '0;
        else if (sum[PIX_W])
            rx = '1;
        else
            rx = sum[PIX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sol   <= 1'b0;
            pix_eof   <= 1'b0;
            frame_err <= 1'b0;
            col       <= '0;
            row       <= '0;
            ra_q      <= '0;
            prev_rb_q <= '0;
        end else begin
            frame_err <= accept && sof_err;
            if (accept) begin
                pix_valid <= 1'b1;
                pix_data  <= rx;
                pix_sol   <= (eff_col == '0);
                pix_eof   <= (eff_col == LAST_COL) && (eff_row == LAST_ROW);
                ra_q      <= rx;
                prev_rb_q <= rb;
                if (eff_col == LAST_COL) begin
                    col <= '0;
                    row <= (eff_row == LAST_ROW) ? '0 : eff_row + RW'(1);
                end else begin
                    col <= eff_col + CW'(1);
                    row <= eff_row;
                end
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

    // Row 0 never reads the line buffer, so its contents need no reset.
    always_ff @(posedge clk) begin
        if (accept)
            linebuf[eff_col] <= rx;
    end

`ifdef PIXEL_RECON_GRAD_EN
    logic [PIX_W-1:0] rd;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    always_comb begin
        if (eff_row == '0)
            rd = '0;
        else if (eff_col == LAST_COL)
            rd = rb;
        else
            rd = linebuf[eff_col + CW'(1)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grad_d1 <= '0;
            grad_d2 <= '0;
            grad_d3 <= '0;
        end else if (accept) begin
            grad_d1 <= abs_diff(rd, rb);
            grad_d2 <= abs_diff(rb, rc);
            grad_d3 <= abs_diff(rc, ra);
        end
    end
`else
    assign grad_d1 = '0;
    assign grad_d2 = '0;
    assign grad_d3 = '0;
`endif

endmodule

// File: tb/tb_pixel_recon.sv
// tb/tb_pixel_recon.sv - scoreboard bench for pixel_recon (optionally with PIXEL_RECON_GRAD_EN)
module tb_pixel_recon;
    localparam int IMAGE_W = 11;
    localparam int IMAGE_H = 9;
    localparam int PIX_W   = 16;
    localparam int NPIX    = IMAGE_W * IMAGE_H;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             res_valid = 1'b0;
    logic             res_ready;
    logic [PIX_W:0]   res_data = '0;
    logic             res_sof = 1'b0;
    logic             pix_valid;
    logic             pix_ready = 1'b0;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sol, pix_eof, frame_err;
    logic [PIX_W-1:0] grad_d1, grad_d2, grad_d3;

    pixel_recon #(.IMAGE_W(IMAGE_W), .IMAGE_H(IMAGE_H), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sof(res_sof),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sol(pix_sol), .pix_eof(pix_eof), .frame_err(frame_err),
        .grad_d1(grad_d1), .grad_d2(grad_d2), .grad_d3(grad_d3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit sol;
        bit eof;
        int d1;
        int d2;
        int d3;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_col = 0, m_row = 0, m_ra = 0, m_prb = 0;
    int   m_lb [IMAGE_W];
    bit   exp_ferr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int med(input int a, input int b, input int c);
        int mx, mn;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        if (c >= mx) return mn;
        if (c <= mn) return mx;
        return a + b - c;
    endfunction

    function automatic void get_nb(input bit sof, output int ra, output int rb, output int rc,
                                   output int rd, output int ec, output int er);
        ec = sof ? 0 : m_col;
        er = sof ? 0 : m_row;
        rb = (er == 0) ? 0 : m_lb[ec];
        rc = (ec == 0) ? rb : m_prb;
        ra = (ec == 0) ? rb : m_ra;
        rd = (er == 0) ? 0 : ((ec == IMAGE_W - 1) ? rb : m_lb[ec + 1]);
    endfunction

    function automatic int predict(input bit sof);
        int ra, rb, rc, rd, ec, er;
        get_nb(sof, ra, rb, rc, rd, ec, er);
        return med(ra, rb, rc);
    endfunction

    function automatic void model_accept(input bit sof, input int res);
        int   ra, rb, rc, rd, ec, er, x;
        exp_t e;
        get_nb(sof, ra, rb, rc, rd, ec, er);
        x = med(ra, rb, rc) + res;
        if (x < 0) x = 0;
        if (x > 65535) x = 65535;
        e.data = x;
        e.sol  = (ec == 0);
        e.eof  = (ec == IMAGE_W - 1) && (er == IMAGE_H - 1);
`ifdef PIXEL_RECON_GRAD_EN
        e.d1 = iabs(rd - rb);
        e.d2 = iabs(rb - rc);
        e.d3 = iabs(rc - ra);
`else
        e.d1 = 0;
        e.d2 = 0;
        e.d3 = 0;
`endif
        sb.push_back(e);
        m_lb[ec] = x;
        m_ra     = x;
        m_prb    = rb;
        if (ec == IMAGE_W - 1) begin
            m_col = 0;
            m_row = (er == IMAGE_H - 1) ? 0 : er + 1;
        end else begin
            m_col = ec + 1;
            m_row = er;
        end
    endfunction

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input bit sof, input int res, input bit prdy, output bit acc);
        bit nxt_ferr;
        res_valid = v;
        res_sof   = sof;
        res_data  = res[PIX_W:0];
        pix_ready = prdy;
        #1;
        chk("pix_valid", pix_valid, sb.size() > 0);
        if (sb.size() > 0) begin
            chk("pix_data", pix_data, sb[0].data);
            chk("pix_sol", pix_sol, sb[0].sol);
            chk("pix_eof", pix_eof, sb[0].eof);
            chk("grad_d1", grad_d1, sb[0].d1);
            chk("grad_d2", grad_d2, sb[0].d2);
            chk("grad_d3", grad_d3, sb[0].d3);
        end
        chk("frame_err", frame_err, exp_ferr);
        chk("res_ready", res_ready, (sb.size() == 0) || prdy);
        acc = v && ((sb.size() == 0) || prdy);
        if (sb.size() > 0 && prdy) void'(sb.pop_front());
        nxt_ferr = 1'b0;
        if (acc) begin
            nxt_ferr = sof && (m_col != 0 || m_row != 0);
            model_accept(sof, res);
        end
        @(negedge clk);
        exp_ferr = nxt_ferr;
    endtask

    task automatic send_pix(input int target, input bit sof);
        bit acc;
        step(1'b1, sof, target - predict(sof), 1'b1, acc);
    endtask

    initial begin
        bit acc;
        int sent, guard;
        foreach (m_lb[i]) m_lb[i] = 0;

        repeat (2) @(negedge clk);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_sol_eof_err", {pix_sol, pix_eof, frame_err}, 0);
        chk("rst_grad", {grad_d1, grad_d2, grad_d3}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First pixel, latency 1, then row-0 prediction from Ra
        step(1'b1, 1'b1, 100, 1'b1, acc);
        chk("t1_valid", pix_valid, 1);
        chk("t1_data", pix_data, 100);
        chk("t1_sol", pix_sol, 1);
        step(1'b1, 1'b0, 5, 1'b1, acc);
        chk("t2_data", pix_data, 105);
        chk("t2_sol", pix_sol, 0);
        chk("t1_ferr", frame_err, 0);

        // Clamping at both ends
        send_pix(65530, 1'b0);
        step(1'b1, 1'b0, 100, 1'b1, acc);
        chk("clamp_hi", pix_data, 65535);
        step(1'b1, 1'b1, 10, 1'b1, acc);
        chk("resync_data", pix_data, 10);
        step(1'b1, 1'b0, -50, 1'b1, acc);
        chk("clamp_lo", pix_data, 0);

        // Output stall: upstream blocked, pixel held
        step(1'b1, 1'b0, 7, 1'b0, acc);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 9, 1'b0, acc);
            chk("stall_ready", res_ready, 0);
        end
        step(1'b1, 1'b0, 9, 1'b1, acc);
        step(1'b0, 1'b0, 0, 1'b1, acc);

        // Full frame: gradient setup, then random residuals under random stall
        send_pix(20, 1'b1);
        send_pix(40, 1'b0);
        send_pix(25, 1'b0);
        for (int i = 3; i < IMAGE_W; i++) send_pix(int'($urandom_range(0, 65535)), 1'b0);
        send_pix(10, 1'b0);
        send_pix(30, 1'b0);
`ifdef PIXEL_RECON_GRAD_EN
        chk("grad_d1_dir", grad_d1, 15);
        chk("grad_d2_dir", grad_d2, 20);
        chk("grad_d3_dir", grad_d3, 10);
`else
        chk("grad_off", {grad_d1, grad_d2, grad_d3}, 0);
`endif
        sent  = IMAGE_W + 2;
        guard = 0;
        while (sent < NPIX && guard < 5000) begin
            step($urandom_range(0, 3) != 0, 1'b0, int'($urandom_range(0, 131071)) - 65536,
                 $urandom_range(0, 2) != 0, acc);
            if (acc) sent++;
            guard++;
        end
        chk("frame_budget", sent, NPIX);
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            step(1'b0, 1'b0, 0, 1'b1, acc);
            guard++;
        end
        chk("drain", sb.size(), 0);

        // Legitimate start of frame, then a misplaced one at pixel 5
        step(1'b1, 1'b1, 50, 1'b1, acc);
        chk("sof_ok_ferr", frame_err, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3, 1'b1, acc);
        step(1'b1, 1'b1, 77, 1'b1, acc);
        chk("sof_bad_ferr", frame_err, 1);
        chk("sof_bad_data", pix_data, 77);
        chk("sof_bad_sol", pix_sol, 1);
        step(1'b1, 1'b0, 4, 1'b1, acc);
        chk("ferr_pulse", frame_err, 0);

        // Asynchronous reset with a pixel pending
        step(1'b1, 1'b0, 6, 1'b0, acc);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", pix_valid, 0);
        chk("mid_rst_data", pix_data, 0);
        chk("mid_rst_flags", {pix_sol, pix_eof, frame_err}, 0);
        sb.delete();
        m_col    = 0;
        m_row    = 0;
        m_ra     = 0;
        m_prb    = 0;
        exp_ferr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 42, 1'b1, acc);
        chk("post_rst_data", pix_data, 42);
        chk("post_rst_sol", pix_sol, 1);
        step(1'b0, 1'b0, 0, 1'b1, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
